// File: rtl/xc_arb_pkg.sv
// Shared definitions for the assign-channel arbiter.
// Provides default sizing, the source-index width helper and the
// arbiter state encoding used when the XC_ARB_LOCK_EN feature is built.
package xc_arb_pkg;

  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned DATA_W_DEF   = 84;
  localparam int unsigned LOCK_MAX_DEF = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned SRC_W_DEF = src_w(N_REQ_DEF);

endpackage

// File: rtl/xc_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i       - candidate request vector
//   ptr_i       - round-robin start index
//   win_o       - lowest set index >= ptr_i, else lowest set index overall
//   any_valid_o - at least one request bit set
module xc_rr_pick
  import xc_arb_pkg::*;
#(
  parameter int unsigned N  = N_REQ_DEF,
  parameter int unsigned SW = src_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [SW-1:0] win_o,
  output logic          any_valid_o
);

  logic          hi_found;
  logic          lo_found;
  logic [SW-1:0] hi_idx;
  logic [SW-1:0] lo_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = SW'(i);
      end
      if (req_i[i] && !hi_found && (i >= 32'(ptr_i))) begin
        hi_found = 1'b1;
        hi_idx   = SW'(i);
      end
    end
    win_o       = hi_found ? hi_idx : lo_idx;
    any_valid_o = |req_i;
  end

endmodule

// File: rtl/xc_assign_arb.sv
// Round-robin arbiter feeding one registered assign-channel stage.
// Optional build macro: XC_ARB_LOCK_EN adds req_lock, the LOCKED state and
// a beat counter that pins the grant to one requester for up to LOCK_MAX beats.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_data    - per-requester words (slot i at [i*DATA_W +: DATA_W])
//   req_ready             - one-hot accept to the current winner
//   req_lock              - per-requester hold-grant request (XC_ARB_LOCK_EN only)
//   out_valid/data/src    - registered channel word and its source index
//   out_ready             - downstream accept
module xc_assign_arb
  import xc_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
`ifdef XC_ARB_LOCK_EN
  input  logic [N_REQ-1:0]           req_lock,
`endif
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [src_w(N_REQ)-1:0]    out_src,
  input  logic                       out_ready
);

  localparam int unsigned SRC_W = src_w(N_REQ);

  if (LOCK_MAX < 1) begin : g_lock_max_chk
    $error("LOCK_MAX must be at least 1");
  end

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] w);
    return (32'(w) == N_REQ - 1) ? '0 : w + SRC_W'(1);
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SRC_W-1:0]  out_src_q,   out_src_d;
  logic [SRC_W-1:0]  rr_ptr_q,    rr_ptr_d;

  logic [N_REQ-1:0]  pick_req;
  logic [SRC_W-1:0]  win;
  logic              any_valid;
  logic              load_en;
  logic              accept;

`ifdef XC_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e        state_q,      state_d;
  logic [SRC_W-1:0]  lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]  lock_cnt_q,   lock_cnt_d;

  // While locked only the owner is a candidate.
  assign pick_req = (state_q == LOCKED) ? (req_valid & (N_REQ'(1) << lock_owner_q))
                                        : req_valid;
`else
  assign pick_req = req_valid;
`endif

  xc_rr_pick #(
    .N  (N_REQ),
    .SW (SRC_W)
  ) u_pick (
    .req_i       (pick_req),
    .ptr_i       (rr_ptr_q),
    .win_o       (win),
    .any_valid_o (any_valid)
  );

  assign load_en = !out_valid_q | out_ready;
  // rst_n gating keeps req_ready low while reset is held.
  assign accept  = rst_n & load_en & any_valid;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef XC_ARB_LOCK_EN
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
`endif

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[int'(win)*DATA_W +: DATA_W];
      out_src_d   = win;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

`ifdef XC_ARB_LOCK_EN
    case (state_q)
      ARB: begin
        if (accept) begin
          // A lock request takes the first beat and freezes rr_ptr; with
          // LOCK_MAX==1 that beat already exhausts the lock.
          if (req_lock[win] && (LOCK_MAX > 1)) begin
            state_d      = LOCKED;
            lock_owner_d = win;
            lock_cnt_d   = CNT_W'(1);
          end else begin
            rr_ptr_d = next_idx(win);
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          if (!req_lock[lock_owner_q] || (32'(lock_cnt_q) + 32'd1 >= LOCK_MAX)) begin
            state_d    = ARB;
            lock_cnt_d = '0;
            rr_ptr_d   = next_idx(lock_owner_q);
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
        end else if (load_en) begin
          // Owner went idle while the stage could take a word.
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
`else
    if (accept) rr_ptr_d = next_idx(win);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      rr_ptr_q     <= '0;
`ifdef XC_ARB_LOCK_EN
      state_q      <= ARB;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      rr_ptr_q     <= rr_ptr_d;
`ifdef XC_ARB_LOCK_EN
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_xc_assign_arb.sv
// Directed self-checking bench for xc_assign_arb (N_REQ=4, DATA_W=84).
module tb_xc_assign_arb;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [4*84-1:0] req_data;
  logic [3:0]      req_ready;
  logic [3:0]      req_lock;
  logic            out_valid;
  logic [83:0]     out_data;
  logic [1:0]      out_src;
  logic            out_ready;

  logic [83:0]     wd [4];
  int              errors = 0;
  int              checks = 0;

  always #5 clk = ~clk;

  xc_assign_arb #(
    .N_REQ    (4),
    .DATA_W   (84),
    .LOCK_MAX (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef XC_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_words;
    wd[0] = 84'h1_1111_0000_0000_0000_00A0;
    wd[1] = 84'h2_2222_0000_0000_0000_00B1;
    wd[2] = 84'h3_3333_0000_0000_0000_00C2;
    wd[3] = 84'h4_4444_0000_0000_0000_00D3;
    for (int i = 0; i < 4; i++) req_data[i*84 +: 84] = wd[i];
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_lock  = 4'h0;
    out_ready = 1'b1;
    load_words();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 84'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d exp 0", out_src); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %b exp 0", out_valid); end
    req_valid = 4'h0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_rr_all;
    logic [3:0] exp_rdy;
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got %b exp 0001", req_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b exp 1", k, out_valid); end
      checks++; if (out_src !== 2'(k % 4)) begin errors++; $display("FAIL rr_src[%0d] got %0d exp %0d", k, out_src, k % 4); end
      checks++; if (out_data !== wd[k % 4]) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", k, out_data, wd[k % 4]); end
      exp_rdy = 4'b0001 << ((k + 1) % 4);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
    end
    req_valid = 4'h0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_stall;
    int delivered = 0;
    req_data[2*84 +: 84] = 84'h0AB_CDEF;
    req_valid = 4'b0100;
    out_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_first_ready got %b exp 0100", req_ready); end
    if (req_valid[2] && req_ready[2]) delivered++;
    tick();
    checks++; if (out_data !== 84'h0AB_CDEF) begin errors++; $display("FAIL stall_load_data got %h exp 0abcdef", out_data); end
    checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL stall_load_src got %0d exp 2", out_src); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", k, req_ready[2]); end
      if (req_valid[2] && req_ready[2]) delivered++;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 84'h0AB_CDEF) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b d=%h exp v=1 d=0abcdef", k, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    req_valid = 4'h0;
    #1;
    if (req_valid[2] && req_ready[2]) delivered++;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", out_valid); end
    checks++; if (delivered !== 1) begin errors++; $display("FAIL stall_count got %0d exp 1", delivered); end
    req_data[2*84 +: 84] = wd[2];
  endtask

  task automatic test_wrap;
    // rr_ptr is 3 after the stall test accepted requester 2.
    req_valid = 4'b0011;
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready0 got %b exp 0001", req_ready); end
    tick();
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL wrap_src0 got %0d exp 0", out_src); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ready1 got %b exp 0010", req_ready); end
    tick();
    checks++; if (out_src !== 2'd1) begin errors++; $display("FAIL wrap_src1 got %0d exp 1", out_src); end
    req_valid = 4'h0;
    tick();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL idle_ptr_ready got %b exp 0100", req_ready); end
    tick();
    checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL idle_ptr_src got %0d exp 2", out_src); end
    req_valid = 4'h0;
    tick();
  endtask

`ifdef XC_ARB_LOCK_EN
  task automatic test_lock;
    rst_n = 1'b0;
    #2;
    rst_n     = 1'b1;
    req_lock  = 4'b0010;
    req_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL lock_pre_src got %0d exp 0", out_src); end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++; if (out_src !== 2'd1) begin errors++; $display("FAIL lock_src[%0d] got %0d exp 1", k, out_src); end
    end
    tick();
    checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL lock_release_src got %0d exp 2", out_src); end
    req_lock  = 4'h0;
    req_valid = 4'h0;
    tick();
  endtask
`endif

  task automatic test_midreset;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin
      errors++; $display("FAIL mid_pre got v=%b src=%0d exp v=1 src=1", out_valid, out_src);
    end
    req_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 84'h0) begin errors++; $display("FAIL mid_data got %h exp 0", out_data); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b exp 0000", req_ready); end
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL post_ready got %b exp 0001", req_ready); end
    tick();
    checks++; if (out_src !== 2'd0 || out_data !== wd[0]) begin
      errors++; $display("FAIL post_src got src=%0d d=%h exp src=0 d=%h", out_src, out_data, wd[0]);
    end
    req_valid = 4'h0;
    tick();
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_stall();
    test_wrap();
`ifdef XC_ARB_LOCK_EN
    test_lock();
`endif
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
